clksel_ctrl: RTL

CLKSEL_CTRL -- requirements
Module: clksel_ctrl

---
 rtl/clksel_pkg.sv | 33 +++
 rtl/clksel_ctrl_sync.sv | 22 ++
 rtl/clksel_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/clksel_pkg.sv
// Shared types and constants for the CPU clock-select controller.
// Holds the state encoding, register address, host windows and CTRL fields.
package clksel_pkg;

  typedef enum logic [1:0] {
    ST_FAST      = 2'd0,
    ST_SLOW_WAIT = 2'd1,
    ST_SLOW      = 2'd2,
    ST_FAST_WAIT = 2'd3
  } state_t;

  localparam logic [23:0] CTRL_ADR  = 24'h00FEFF;
  localparam logic [7:0]  HOST_BANK = 8'h00;

  localparam logic [15:0] IO_LO  = 16'hFC00;
  localparam logic [15:0] IO_HI  = 16'hFEFE;
  localparam logic [15:0] SHD_LO = 16'h3000;
  localparam logic [15:0] SHD_HI = 16'h7FFF;

  localparam int DIV_LSB    = 0;
  localparam int TURBO_BIT  = 2;
  localparam int SHADOW_BIT = 3;
  localparam int HOLD_LSB   = 4;

  function automatic logic in_rng(
    input logic [15:0] a,
    input logic [15:0] lo,
    input logic [15:0] hi
  );
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/clksel_ctrl_sync.sv
// Two-flop synchroniser for the clock-switch acknowledges.
// Clears to 0 on reset so no stale acknowledge is seen afterwards.
module sync_2ff (
  input  logic cpuclk,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge cpuclk or negedge rst_b) begin
    if (!rst_b) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clksel_ctrl.sv
// CPU clock-select controller: drops to the slow clock for host cycles
// and returns to the fast clock after a programmable idle hold.
module clksel_ctrl
  import clksel_pkg::*;
(
  input  logic        cpuclk,
  input  logic        rst_b,
  input  logic [23:0] cpu_adr,
  input  logic        vda,
  input  logic        vpa,
  input  logic        rnw,
  input  logic [7:0]  cpu_data_in,
  input  logic        hsclk_selected,
  input  logic        lsclk_selected,
  output logic        hsclk_sel,
  output logic [1:0]  cpuclk_div_sel,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  output logic        host_access
);

  state_t      state;
  logic [7:0]  ctrl_q;
  logic [3:0]  cnt;
  logic        valid;
  logic        ctrl_hit;
  logic        host_hit;
  logic        hs_ack;
  logic        ls_ack;
  logic        turbo_en;
  logic        shadow_en;
  logic [3:0]  hold_cnt;
  logic [1:0]  div_sel;
  logic [15:0] ofs;

  sync_2ff u_hs_sync (
    .cpuclk (cpuclk),
    .rst_b  (rst_b),
    .d      (hsclk_selected),
    .q      (hs_ack)
  );

  sync_2ff u_ls_sync (
    .cpuclk (cpuclk),
    .rst_b  (rst_b),
    .d      (lsclk_selected),
    .q      (ls_ack)
  );

  assign valid     = vda | vpa;
  assign ofs       = cpu_adr[15:0];
  assign ctrl_hit  = valid && (cpu_adr == CTRL_ADR);
  assign turbo_en  = ctrl_q[TURBO_BIT];
  assign shadow_en = ctrl_q[SHADOW_BIT];
  assign hold_cnt  = ctrl_q[HOLD_LSB +: 4];
  assign div_sel   = ctrl_q[DIV_LSB +: 2];

  always_comb begin
    host_hit = 1'b0;
    if (valid && (cpu_adr[23:16] == HOST_BANK)) begin
      host_hit = in_rng(ofs, IO_LO, IO_HI)
              || (!shadow_en && in_rng(ofs, SHD_LO, SHD_HI));
    end
  end

  assign host_access  = host_hit;
  assign cpu_data_oe  = ctrl_hit && rnw;
  assign cpu_data_out = cpu_data_oe ? ctrl_q : 8'h00;

  // Combinational so a host cycle drops the fast clock in its own cycle.
  assign hsclk_sel = ((state == ST_FAST) || (state == ST_FAST_WAIT))
                  && !host_hit;

  always_ff @(posedge cpuclk or negedge rst_b) begin
    if (!rst_b) begin
      ctrl_q <= 8'h00;
    end else if (ctrl_hit && !rnw) begin
      ctrl_q <= cpu_data_in;
    end
  end

  always_ff @(posedge cpuclk or negedge rst_b) begin
    if (!rst_b) begin
      state          <= ST_SLOW;
      cnt            <= 4'd0;
      cpuclk_div_sel <= 2'b00;
    end else begin
      unique case (state)
        ST_FAST: begin
          if (host_hit || !turbo_en) state <= ST_SLOW_WAIT;
        end
        ST_SLOW_WAIT: begin
          if (ls_ack) begin
            state <= ST_SLOW;
            cnt   <= hold_cnt;
          end
        end
        ST_SLOW: begin
          // Divider only moves while the fast clock is off.
          cpuclk_div_sel <= div_sel;
          if (host_hit) begin
            cnt <= hold_cnt;
          end else begin
            if (cnt != 4'd0) cnt <= cnt - 4'd1;
            if ((cnt == 4'd0) && turbo_en) state <= ST_FAST_WAIT;
          end
        end
        ST_FAST_WAIT: begin
          if (host_hit || !turbo_en) state <= ST_SLOW_WAIT;
          else if (hs_ack)           state <= ST_FAST;
        end
        default: state <= ST_SLOW;
      endcase
    end
  end

endmodule
